// File: rtl/bs_notch_power_meter_if.sv
// Sample stream and result bundle for the notch power meter.
// master drives samples/start; slave returns status and results.
interface bs_notch_power_meter_if #(
  parameter int WL = 28
);
  logic                 en;
  logic                 start;
  logic signed [WL-1:0] y_in;
  logic                 busy;
  logic                 done;
  logic [2*WL-1:0]      ms_out;
  logic [WL-1:0]        pk_out;

  modport master (
    output en, start, y_in,
    input  busy, done, ms_out, pk_out
  );

  modport slave (
    input  en, start, y_in,
    output busy, done, ms_out, pk_out
  );
endinterface

// File: rtl/bs_notch_power_meter.sv
// Mean-square and peak meter for the band-stop IIR output stream.
// Discards SETTLE samples, then measures a 2**WIN_LOG2 window.
module bs_notch_power_meter #(
  parameter int WL       = 28,
  parameter int WIN_LOG2 = 4,
  parameter int SETTLE   = 8
) (
  input logic clk,
  input logic reset,
  bs_notch_power_meter_if.slave m
);

  localparam int WIN  = 1 << WIN_LOG2;
  localparam int PW   = 2*WL - 1;
  localparam int AW   = PW + WIN_LOG2;
  localparam int CMAX = (SETTLE > WIN) ? SETTLE : WIN;
  localparam int CW   = $clog2(CMAX + 1);

  localparam logic [CW-1:0] SET_LAST =
    CW'((SETTLE > 0) ? SETTLE - 1 : 0);
  localparam logic [CW-1:0] WIN_LAST = CW'(WIN - 1);
  localparam logic [WL-1:0] MAG_MAX  = {1'b0, {(WL-1){1'b1}}};
  localparam logic [WL-1:0] NEG_MIN  = {1'b1, {(WL-1){1'b0}}};

  typedef enum logic [1:0] {
    IDLE,
    SETL,
    ACCU,
    DONE
  } state_t;

  state_t state, state_d;

  logic [CW-1:0]   cnt, cnt_d, cnt_b;
  logic [AW-1:0]   acc, acc_d, acc_b;
  logic [WL-1:0]   peak, peak_d, peak_b;
  logic [2*WL-1:0] ms, ms_d;
  logic [WL-1:0]   pk, pk_d;
  logic [WL-1:0]   mag;
  logic signed [PW-1:0] yx;
  logic signed [PW-1:0] prod;
  logic [PW-1:0]   sq;
  logic go;
  logic take_set;
  logic take_acc;

  // Square is always non-negative and at most 2**(2*WL-2),
  // so PW bits hold it exactly, including the most negative input.
  assign yx   = {{(WL-1){m.y_in[WL-1]}}, m.y_in};
  assign prod = yx * yx;
  assign sq   = prod;

  always_comb begin
    mag = m.y_in;
    if (m.y_in[WL-1]) begin
      if (m.y_in == NEG_MIN) mag = MAG_MAX;
      else                   mag = ~m.y_in + 1'b1;
    end
  end

  // A start shares its cycle with the first sample of the run,
  // so the cleared values feed the same-cycle update.
  assign go       = (state == IDLE) && m.start;
  assign take_set = m.en &&
    ((state == SETL) || (go && SETTLE != 0));
  assign take_acc = m.en &&
    ((state == ACCU) || (go && SETTLE == 0));

  assign cnt_b  = go ? '0 : cnt;
  assign acc_b  = go ? '0 : acc;
  assign peak_b = go ? '0 : peak;

  always_comb begin
    state_d = state;
    cnt_d   = cnt_b;
    acc_d   = acc_b;
    peak_d  = peak_b;
    ms_d    = ms;
    pk_d    = pk;

    unique case (state)
      IDLE: if (go) state_d = (SETTLE == 0) ? ACCU : SETL;
      SETL: state_d = SETL;
      ACCU: state_d = ACCU;
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase

    if (take_set) begin
      if (cnt_b == SET_LAST) begin
        cnt_d   = '0;
        state_d = ACCU;
      end else begin
        cnt_d = cnt_b + CW'(1);
      end
    end

    if (take_acc) begin
      acc_d  = acc_b + AW'(sq);
      peak_d = (mag > peak_b) ? mag : peak_b;
      if (cnt_b == WIN_LAST) begin
        cnt_d   = '0;
        state_d = DONE;
        ms_d    = {1'b0, acc_d[AW-1:WIN_LOG2]};
        pk_d    = peak_d;
      end else begin
        cnt_d = cnt_b + CW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      cnt   <= '0;
      acc   <= '0;
      peak  <= '0;
      ms    <= '0;
      pk    <= '0;
    end else begin
      state <= state_d;
      cnt   <= cnt_d;
      acc   <= acc_d;
      peak  <= peak_d;
      ms    <= ms_d;
      pk    <= pk_d;
    end
  end

  assign m.busy   = (state == SETL) || (state == ACCU);
  assign m.done   = (state == DONE);
  assign m.ms_out = ms;
  assign m.pk_out = pk;

endmodule

// File: tb/tb_bs_notch_power_meter.sv
// Directed bench for bs_notch_power_meter.
// Sample-list model checked every cycle plus literal results.
module tb_bs_notch_power_meter;

  localparam int WL     = 28;
  localparam int SETTLE = 8;
  localparam int WIN    = 16;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  bs_notch_power_meter_if #(.WL(WL)) bus ();

  bs_notch_power_meter #(
    .WL(WL),
    .WIN_LOG2(4),
    .SETTLE(SETTLE)
  ) dut (
    .clk(clk),
    .reset(reset),
    .m(bus)
  );

  int vectors     = 0;
  int miscompares = 0;
  int cyc         = 0;
  int done_pulses = 0;
  bit chk_on      = 0;

  always @(posedge clk) cyc++;

  task automatic chk(input string name,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, want %0d", name, act, exp);
    end
  endtask

  // Model: collect accepted samples of a run, results from the list.
  bit          meas;
  bit          was_done;
  bit          m_busy;
  bit          m_done;
  logic [55:0] m_ms;
  logic [27:0] m_pk;
  longint      q[$];

  task automatic model_result();
    longint s;
    longint p;
    longint v;
    longint a;
    s = 0;
    p = 0;
    for (int i = SETTLE; i < SETTLE + WIN; i++) begin
      v = q[i];
      s += v * v;
      a = (v < 0) ? -v : v;
      if (a > 134217727) a = 134217727;
      if (a > p) p = a;
    end
    m_ms = 56'(s / WIN);
    m_pk = 28'(p);
  endtask

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      meas   = 0;
      m_busy = 0;
      m_done = 0;
      m_ms   = '0;
      m_pk   = '0;
      q.delete();
    end else begin
      was_done = m_done;
      m_done   = 0;
      if (!meas && !was_done && bus.start) begin
        meas = 1;
        q.delete();
      end
      if (meas && bus.en) q.push_back(longint'(bus.y_in));
      if (meas && q.size() == SETTLE + WIN) begin
        model_result();
        m_done = 1;
        meas   = 0;
      end
      m_busy = meas;
    end
  end

  always @(negedge clk) begin
    if (chk_on) begin
      chk("busy",   64'(bus.busy),   64'(m_busy));
      chk("done",   64'(bus.done),   64'(m_done));
      chk("ms_out", 64'(bus.ms_out), 64'(m_ms));
      chk("pk_out", 64'(bus.pk_out), 64'(m_pk));
      if (bus.done) done_pulses++;
    end
  end

  function automatic logic signed [27:0] pat_val(input int pat,
                                                 input int k);
    int v;
    case (pat)
      0: v = 819200;
      1: case (k % 4)
           1: v = 819200;
           3: v = -819200;
           default: v = 0;
         endcase
      2: v = -134217728;
      default: v = 0;
    endcase
    return v[27:0];
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic measure(input int pat, input int period,
                         input int restart_at, input int exp_lat,
                         input string tag);
    int k;
    int t0;
    bit got;
    k  = 0;
    t0 = 0;
    got = 0;
    for (int i = 0; i < 300 && !got; i++) begin
      tick();
      if (i == 0) t0 = cyc;
      bus.start = (i == 0) || (i == restart_at);
      bus.en    = (i % period) == 0;
      bus.y_in  = pat_val(pat, k);
      if (bus.en) k++;
      @(negedge clk);
      if (bus.done) begin
        got = 1;
        chk({tag, " latency"}, 64'(cyc - t0), 64'(exp_lat));
      end
    end
    if (!got) chk({tag, " timeout"}, 64'd0, 64'd1);
    tick();
    bus.start = 0;
    bus.en    = 0;
    bus.y_in  = '0;
  endtask

  task automatic results(input string tag,
                         input logic [63:0] ms,
                         input logic [63:0] pk);
    chk({tag, " ms literal"}, 64'(bus.ms_out), ms);
    chk({tag, " pk literal"}, 64'(bus.pk_out), pk);
  endtask

  int p0;

  initial begin
    reset     = 1'b0;
    bus.start = 1'b0;
    bus.en    = 1'b0;
    bus.y_in  = '0;
    tick();
    chk_on = 1;
    chk("reset busy", 64'(bus.busy), 64'd0);
    chk("reset done", 64'(bus.done), 64'd0);
    results("reset", 64'd0, 64'd0);
    tick();
    reset = 1'b1;

    // en without start does nothing
    bus.en   = 1'b1;
    bus.y_in = pat_val(0, 0);
    repeat (4) tick();
    bus.en = 1'b0;
    chk("idle busy", 64'(bus.busy), 64'd0);

    measure(0, 1, -1, 24, "t1");
    results("t1", 64'd671088640000, 64'd819200);

    measure(1, 1, -1, 24, "t2");
    results("t2", 64'd335544320000, 64'd819200);

    measure(2, 1, -1, 24, "t3");
    results("t3", 64'd1 << 54, 64'd134217727);

    measure(0, 3, -1, 70, "t4");
    results("t4", 64'd671088640000, 64'd819200);

    p0 = done_pulses;
    measure(0, 1, 14, 24, "t5");
    repeat (10) tick();
    chk("t5 done pulses", 64'(done_pulses - p0), 64'd1);
    results("t5", 64'd671088640000, 64'd819200);

    tick();
    bus.start = 1'b1;
    bus.en    = 1'b1;
    bus.y_in  = pat_val(0, 0);
    tick();
    bus.start = 1'b0;
    repeat (11) tick();
    chk("t6 busy before reset", 64'(bus.busy), 64'd1);
    reset = 1'b0;
    #1;
    chk("t6 rst busy", 64'(bus.busy), 64'd0);
    chk("t6 rst done", 64'(bus.done), 64'd0);
    results("t6 rst", 64'd0, 64'd0);
    tick();
    bus.en = 1'b0;
    reset  = 1'b1;
    p0 = done_pulses;
    repeat (20) tick();
    chk("t6 no done", 64'(done_pulses - p0), 64'd0);
    measure(3, 1, -1, 24, "t6");
    results("t6", 64'd0, 64'd0);

    repeat (3) tick();
    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
